seq_detect_p: RTL and testbench

Parametrised serial pattern detector, successor to the fixed single-pattern `fsm_3` detector. It samples one serial bit per enabled clock and compares the most recent `PAT_W` bits against a configurable `PATTERN`. It emits a one-cycle `match` pulse, supports overlapping and non-overlapping detection selected at run time, and optionally keeps a saturating match count. It sits on the serial data path downstream of the bit source and feeds the status/counter logic.

---
 rtl/seq_detect_pkg.sv | 16 +
 rtl/seq_sat_counter.sv | 33 +++
 rtl/seq_detect_p.sv | 92 +++++++++
 tb/tb_seq_detect_p.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the seq_detect_p serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } seq_state_e;

  localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1010;

  // Width needed to count 0..pat_w valid history bits.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins, otherwise increment until all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign sat = (cnt_r == CNT_MAX);

endmodule

// File: rtl/seq_detect_p.sv
// Parametrised serial pattern detector with overlap select and registered match pulse.
// Optional saturating match counter is built when SEQ_DETECT_CNT_EN is defined.
module seq_detect_p
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_DEF_PATTERN),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int             FW        = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_r;
  logic [PAT_W-1:0] hist_nx_s;
  logic [FW-1:0]    fill_r;
  logic [FW-1:0]    fill_nx_s;
  seq_state_e       state_r;
  logic             match_r;
  logic             hit_s;

  // Next history/fill and the match decision for the current sample.
  always_comb begin
    hist_nx_s = {hist_r[PAT_W-2:0], din};
    case (state_r)
      S_ARMED: fill_nx_s = fill_r;
      S_FILL:  fill_nx_s = fill_r + FW'(1);
      default: fill_nx_s = fill_r;
    endcase
    hit_s = en && !clr && (hist_nx_s == PATTERN) && (fill_nx_s == FILL_FULL);
  end

  // Detector FSM: history shift, fill tracking and registered match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r  <= {PAT_W{1'b0}};
      fill_r  <= {FW{1'b0}};
      state_r <= S_FILL;
      match_r <= 1'b0;
    end else if (clr) begin
      hist_r  <= {PAT_W{1'b0}};
      fill_r  <= {FW{1'b0}};
      state_r <= S_FILL;
      match_r <= 1'b0;
    end else if (en) begin
      hist_r  <= hist_nx_s;
      match_r <= hit_s;
      if (hit_s && !overlap) begin
        // Non-overlapping: the next match must be built from fresh bits.
        fill_r  <= {FW{1'b0}};
        state_r <= S_FILL;
      end else begin
        fill_r  <= fill_nx_s;
        state_r <= (fill_nx_s == FILL_FULL) ? S_ARMED : S_FILL;
      end
    end else begin
      hist_r  <= hist_r;
      fill_r  <= fill_r;
      state_r <= state_r;
      match_r <= 1'b0;
    end
  end

  assign match = match_r;

`ifdef SEQ_DETECT_CNT_EN
  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (hit_s),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );
`else
  assign match_cnt = {CNT_W{1'b0}};
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_p.sv
// Self-checking bench for seq_detect_p: directed scenarios plus random traffic vs a window model.
module tb_seq_detect_p;

  localparam int             PAT_W = 4;
  localparam logic [PAT_W-1:0] PAT = 4'b1010;
  localparam int             CNT_W = 8;
`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             din = 1'b0;
  logic             overlap = 1'b0;
  logic             clr = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  int checks = 0;
  int passed = 0;
  int pulses = 0;

  // Reference model: bits collected since the last fresh start, plus a true match count.
  bit   win_q[$];
  int   exp_cnt = 0;
  logic exp_match = 1'b0;

  seq_detect_p #(.PAT_W(PAT_W), .PATTERN(PAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .overlap   (overlap),
    .clr       (clr),
    .match     (match),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int cnt_out();
    return CNT_EN ? exp_cnt : 0;
  endfunction

  task automatic check_outputs(input string tag);
    int max_cnt;
    max_cnt = (1 << CNT_W) - 1;
    check({tag, ".match"}, {31'd0, match}, {31'd0, exp_match});
    check({tag, ".match_cnt"}, {24'd0, match_cnt}, cnt_out());
    check({tag, ".cnt_sat"}, {31'd0, cnt_sat}, {31'd0, (CNT_EN && exp_cnt == max_cnt)});
    if (match === 1'b1) pulses++;
  endtask

  task automatic model(input logic e, input logic d, input logic c, input logic o);
    logic [PAT_W-1:0] w;
    exp_match = 1'b0;
    if (c) begin
      win_q.delete();
      exp_cnt = 0;
    end else if (e) begin
      win_q.push_back(d);
      if (win_q.size() > PAT_W) void'(win_q.pop_front());
      if (win_q.size() == PAT_W) begin
        w = '0;
        foreach (win_q[i]) w[PAT_W-1-i] = win_q[i];
        if (w == PAT) begin
          exp_match = 1'b1;
          if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
          if (!o) win_q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c, input logic o, input string tag);
    en = e; din = d; clr = c; overlap = o;
    model(e, d, c, o);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    win_q.delete();
    exp_cnt = 0;
    exp_match = 1'b0;
    #1;
    check_outputs({tag, ".async"});
    @(posedge clk); #1;
    check_outputs(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    apply_reset("reset");

    // Overlap run: 0,0 then 1010... for 32 bits.
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1, "ovl");
    step(1'b1, 1'b0, 1'b0, 1'b1, "ovl");
    for (int i = 0; i < 32; i++) step(1'b1, (i % 2 == 0), 1'b0, 1'b1, "ovl");
    check("ovl.pulses", pulses, 15);
    check("ovl.cnt", {24'd0, match_cnt}, CNT_EN ? 15 : 0);

    // Non-overlap run after clr: 0101... for 32 bits.
    step(1'b1, 1'b0, 1'b1, 1'b0, "nov.clr");
    pulses = 0;
    for (int i = 0; i < 32; i++) step(1'b1, (i % 2 == 1), 1'b0, 1'b0, "nov");
    check("nov.pulses", pulses, 7);
    check("nov.cnt", {24'd0, match_cnt}, CNT_EN ? 7 : 0);

    // Reset mid-pattern.
    step(1'b1, 1'b0, 1'b1, 1'b1, "rmid.clr");
    step(1'b1, 1'b1, 1'b0, 1'b1, "rmid");
    step(1'b1, 1'b0, 1'b0, 1'b1, "rmid");
    step(1'b1, 1'b1, 1'b0, 1'b1, "rmid");
    apply_reset("rmid.rst");
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1, "rmid.after");
    check("rmid.nopulse", pulses, 0);
    check("rmid.cnt0", {24'd0, match_cnt}, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "rmid2");
    step(1'b1, 1'b0, 1'b0, 1'b1, "rmid2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "rmid2");
    step(1'b1, 1'b0, 1'b0, 1'b1, "rmid2");
    check("rmid.pulses", pulses, 1);

    // clr collides with the completing bit; history must restart from scratch.
    step(1'b1, 1'b0, 1'b1, 1'b1, "clrc.pre");
    step(1'b1, 1'b1, 1'b0, 1'b1, "clrc");
    step(1'b1, 1'b0, 1'b0, 1'b1, "clrc");
    step(1'b1, 1'b1, 1'b0, 1'b1, "clrc");
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 1'b1, "clrc.hit");
    check("clrc.cnt0", {24'd0, match_cnt}, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "clrc.refill");
    step(1'b1, 1'b0, 1'b0, 1'b1, "clrc.refill");
    step(1'b1, 1'b1, 1'b0, 1'b1, "clrc.refill");
    check("clrc.nopulse", pulses, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, "clrc.refill");
    check("clrc.pulses", pulses, 1);

    // Enable gating: din toggles while en is low.
    step(1'b1, 1'b0, 1'b1, 1'b1, "engate.clr");
    pulses = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, "engate");
    step(1'b1, 1'b0, 1'b0, 1'b1, "engate");
    for (int i = 0; i < 5; i++) step(1'b0, (i % 2 == 0), 1'b0, 1'b1, "engate.off");
    check("engate.quiet", pulses, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "engate");
    step(1'b1, 1'b0, 1'b0, 1'b1, "engate");
    check("engate.pulses", pulses, 1);

    // Long overlap stream to drive the counter into saturation.
    step(1'b1, 1'b0, 1'b1, 1'b1, "sat.clr");
    pulses = 0;
    for (int i = 0; i < 600; i++) step(1'b1, (i % 2 == 0), 1'b0, 1'b1, "sat");
    check("sat.pulses", pulses, 299);
    check("sat.cnt", {24'd0, match_cnt}, CNT_EN ? 255 : 0);

    // Random traffic against the window model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 8) != 0, $urandom % 2, ($urandom % 64) == 0,
           ($urandom % 4) != 0, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
